pic_arbiter: RTL and testbench

PIC_ARBITER -- requirements
Module: pic_arbiter

---
 rtl/pic_arbiter.sv | 141 ++++++++++++++
 tb/tb_pic_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pic_arbiter.sv
// Single-level 8-line interrupt controller: IRR/IMR/ISR with fixed priority,
// toggle-type interrupt output to the core and a small CPU I/O register port.
module pic_arbiter #(
    parameter int unsigned VBASE     = 8,
    parameter logic [15:0] PORT_CMD  = 16'h0020,
    parameter logic [15:0] PORT_MASK = 16'h0021
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  irq_req,
    input  logic [15:0] port_a,
    input  logic        port_w,
    input  logic        port_r,
    input  logic [7:0]  port_o,
    output logic [7:0]  port_i,
    output logic        port_hit,
    output logic        irq,
    output logic [7:0]  irq_in
);

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_t;

    localparam logic [7:0] VBASE8 = 8'(VBASE);

    state_t     state_q, state_d;
    logic [7:0] irr_q, irr_d;
    logic [7:0] imr_q, imr_d;
    logic [7:0] isr_q, isr_d;
    logic       rsel_q, rsel_d;
    logic       irq_q, irq_d;
    logic [7:0] vec_q, vec_d;
    logic [7:0] rdata_q, rdata_d;
    logic       hit_q, hit_d;

    logic [7:0] pend_c;
    logic [7:0] irr_clr_c;
    logic [2:0] pick_c;
    logic       cmd_wr_c;
    logic       mask_wr_c;

    // State and register file
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            irr_q   <= 8'h00;
            imr_q   <= 8'h00;
            isr_q   <= 8'h00;
            rsel_q  <= 1'b0;
            irq_q   <= 1'b0;
            vec_q   <= VBASE8;
            rdata_q <= 8'h00;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            irr_q   <= irr_d;
            imr_q   <= imr_d;
            isr_q   <= isr_d;
            rsel_q  <= rsel_d;
            irq_q   <= irq_d;
            vec_q   <= vec_d;
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
        end
    end

    // Next-state: issue decision uses the pre-edge IMR; new requests beat the issue clear
    always_comb begin
        state_d   = state_q;
        imr_d     = imr_q;
        isr_d     = isr_q;
        rsel_d    = rsel_q;
        irq_d     = irq_q;
        vec_d     = vec_q;
        rdata_d   = rdata_q;
        hit_d     = 1'b0;
        irr_clr_c = 8'h00;
        pick_c    = 3'd0;

        pend_c    = irr_q & ~imr_q;
        cmd_wr_c  = port_w && (port_a == PORT_CMD);
        mask_wr_c = port_w && (port_a == PORT_MASK);

        for (int i = 7; i >= 0; i--) begin
            if (pend_c[i]) begin
                pick_c = 3'(i);
            end
        end

        case (state_q)
            IDLE: begin
                if (pend_c != 8'h00) begin
                    irq_d     = ~irq_q;
                    vec_d     = VBASE8 + {5'b00000, pick_c};
                    irr_clr_c = 8'h01 << pick_c;
                    isr_d     = 8'h01 << pick_c;
                    state_d   = SERVICE;
                end
            end
            SERVICE: begin
                if (cmd_wr_c && port_o[5]) begin
                    isr_d   = 8'h00;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        irr_d = (irr_q & ~irr_clr_c) | irq_req;

        if (mask_wr_c) begin
            imr_d = port_o;
        end

        if (cmd_wr_c && !port_o[5]) begin
            if (port_o[1:0] == 2'b10) begin
                rsel_d = 1'b0;
            end else if (port_o[1:0] == 2'b11) begin
                rsel_d = 1'b1;
            end
        end

        if (port_r) begin
            if (port_a == PORT_CMD) begin
                rdata_d = rsel_q ? isr_q : irr_q;
                hit_d   = 1'b1;
            end else if (port_a == PORT_MASK) begin
                rdata_d = imr_q;
                hit_d   = 1'b1;
            end
        end
    end

    assign port_i   = rdata_q;
    assign port_hit = hit_q;
    assign irq      = irq_q;
    assign irq_in   = vec_q;

endmodule

// File: tb/tb_pic_arbiter.sv
// Directed bench for pic_arbiter: per-cycle vector table plus hand sequences
// for reset-in-service, re-pulse on issue and vector wrap.
module tb_pic_arbiter;

    localparam logic [15:0] C = 16'h0020;
    localparam logic [15:0] M = 16'h0021;
    localparam logic [15:0] X = 16'h0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  irq_req;
    logic [15:0] port_a;
    logic        port_w;
    logic        port_r;
    logic [7:0]  port_o;
    logic [7:0]  port_i;
    logic        port_hit;
    logic        irq;
    logic [7:0]  irq_in;
    logic [7:0]  w_port_i;
    logic        w_port_hit;
    logic        w_irq;
    logic [7:0]  w_irq_in;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pic_arbiter dut (
        .clock(clock), .reset_n(reset_n), .irq_req(irq_req), .port_a(port_a),
        .port_w(port_w), .port_r(port_r), .port_o(port_o), .port_i(port_i),
        .port_hit(port_hit), .irq(irq), .irq_in(irq_in)
    );

    pic_arbiter #(.VBASE(252)) u_wrap (
        .clock(clock), .reset_n(reset_n), .irq_req(irq_req), .port_a(port_a),
        .port_w(port_w), .port_r(port_r), .port_o(port_o), .port_i(w_port_i),
        .port_hit(w_port_hit), .irq(w_irq), .irq_in(w_irq_in)
    );

    typedef struct {
        logic [7:0]  req;
        logic [15:0] a;
        logic        w;
        logic        r;
        logic [7:0]  o;
        logic        eirq;
        logic [7:0]  evec;
        logic [7:0]  epi;
        logic        ehit;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] req, input logic [15:0] a, input logic w,
                       input logic r, input logic [7:0] o, input logic eirq,
                       input logic [7:0] evec, input logic [7:0] epi, input logic ehit);
        vec_t v;
        v.req = req; v.a = a; v.w = w; v.r = r; v.o = o;
        v.eirq = eirq; v.evec = evec; v.epi = epi; v.ehit = ehit;
        tbl.push_back(v);
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // One clock: drive, take the edge, release strobes, leave outputs settled for checking
    task automatic cyc(input logic [7:0] req, input logic [15:0] a, input logic w,
                       input logic r, input logic [7:0] o);
        irq_req = req; port_a = a; port_w = w; port_r = r; port_o = o;
        @(posedge clock);
        #1;
        irq_req = 8'h00; port_a = X; port_w = 1'b0; port_r = 1'b0; port_o = 8'h00;
    endtask

    task automatic chk_out(input string nm, input logic eirq, input logic [7:0] evec,
                           input logic [7:0] epi, input logic ehit);
        chk1({nm, " irq"}, irq, eirq);
        chk8({nm, " irq_in"}, irq_in, evec);
        chk8({nm, " port_i"}, port_i, epi);
        chk1({nm, " port_hit"}, port_hit, ehit);
    endtask

    initial begin
        reset_n = 1'b0;
        irq_req = 8'h00; port_a = X; port_w = 1'b0; port_r = 1'b0; port_o = 8'h00;

        // Vector table: each row is one clock, expected outputs just after that edge
        add(8'h00, X, 0, 0, 8'h00, 0, 8'd8,  8'h00, 0);
        add(8'h01, X, 0, 0, 8'h00, 0, 8'd8,  8'h00, 0);
        add(8'h00, X, 0, 0, 8'h00, 1, 8'd8,  8'h00, 0);
        add(8'h00, C, 0, 1, 8'h00, 1, 8'd8,  8'h00, 1);
        add(8'h00, C, 1, 0, 8'h0B, 1, 8'd8,  8'h00, 0);
        add(8'h00, C, 0, 1, 8'h00, 1, 8'd8,  8'h01, 1);
        add(8'h00, C, 1, 0, 8'h20, 1, 8'd8,  8'h01, 0);
        add(8'h00, C, 1, 0, 8'h0A, 1, 8'd8,  8'h01, 0);
        add(8'h06, X, 0, 0, 8'h00, 1, 8'd8,  8'h01, 0);
        add(8'h00, X, 0, 0, 8'h00, 0, 8'd9,  8'h01, 0);
        add(8'h00, X, 0, 0, 8'h00, 0, 8'd9,  8'h01, 0);
        add(8'h00, C, 0, 1, 8'h00, 0, 8'd9,  8'h04, 1);
        add(8'h00, C, 1, 0, 8'h20, 0, 8'd9,  8'h04, 0);
        add(8'h00, X, 0, 0, 8'h00, 1, 8'd10, 8'h04, 0);
        add(8'h00, C, 1, 0, 8'h20, 1, 8'd10, 8'h04, 0);
        add(8'h00, M, 1, 0, 8'h01, 1, 8'd10, 8'h04, 0);
        add(8'h01, X, 0, 0, 8'h00, 1, 8'd10, 8'h04, 0);
        add(8'h00, X, 0, 0, 8'h00, 1, 8'd10, 8'h04, 0);
        add(8'h00, C, 0, 1, 8'h00, 1, 8'd10, 8'h01, 1);
        add(8'h00, M, 0, 1, 8'h00, 1, 8'd10, 8'h01, 1);
        add(8'h00, M, 1, 0, 8'h00, 1, 8'd10, 8'h01, 0);
        add(8'h00, X, 0, 0, 8'h00, 0, 8'd8,  8'h01, 0);
        add(8'h00, C, 1, 0, 8'h20, 0, 8'd8,  8'h01, 0);
        add(8'h00, M, 1, 0, 8'hF0, 0, 8'd8,  8'h01, 0);
        add(8'h08, X, 0, 0, 8'h00, 0, 8'd8,  8'h01, 0);
        add(8'h00, X, 0, 0, 8'h00, 1, 8'd11, 8'h01, 0);
        add(8'h00, C, 1, 0, 8'h0B, 1, 8'd11, 8'h01, 0);
        add(8'h00, C, 0, 1, 8'h00, 1, 8'd11, 8'h08, 1);
        add(8'h00, X, 0, 0, 8'h00, 1, 8'd11, 8'h08, 0);
        add(8'h00, M, 0, 1, 8'h00, 1, 8'd11, 8'hF0, 1);
        add(8'h00, 16'h0022, 0, 1, 8'h00, 1, 8'd11, 8'hF0, 0);
        add(8'h00, 16'h0120, 1, 0, 8'h20, 1, 8'd11, 8'hF0, 0);
        add(8'h01, X, 0, 0, 8'h00, 1, 8'd11, 8'hF0, 0);
        add(8'h00, X, 0, 0, 8'h00, 1, 8'd11, 8'hF0, 0);
        add(8'h00, C, 1, 0, 8'h20, 1, 8'd11, 8'hF0, 0);
        add(8'h00, X, 0, 0, 8'h00, 0, 8'd8,  8'hF0, 0);
        add(8'h00, C, 1, 0, 8'h20, 0, 8'd8,  8'hF0, 0);
        add(8'h00, C, 1, 0, 8'h20, 0, 8'd8,  8'hF0, 0);

        repeat (2) @(posedge clock);
        #1;
        chk_out("reset", 1'b0, 8'd8, 8'h00, 1'b0);
        chk8("reset wrap irq_in", w_irq_in, 8'd252);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            cyc(tbl[i].req, tbl[i].a, tbl[i].w, tbl[i].r, tbl[i].o);
            chk_out($sformatf("row%0d", i), tbl[i].eirq, tbl[i].evec, tbl[i].epi, tbl[i].ehit);
        end

        // Reset while servicing IRQ0 with IRQ4 pending and a non-zero mask
        cyc(8'h00, M, 1, 0, 8'h40);
        cyc(8'h01, X, 0, 0, 8'h00);
        cyc(8'h00, X, 0, 0, 8'h00);
        chk1("pre-reset issue irq", irq, 1'b1);
        cyc(8'h10, X, 0, 0, 8'h00);
        cyc(8'h00, C, 1, 0, 8'h0B);
        reset_n = 1'b0;
        cyc(8'hFF, X, 0, 0, 8'h00);
        cyc(8'hFF, X, 0, 0, 8'h00);
        chk_out("in reset", 1'b0, 8'd8, 8'h00, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(8'h00, X, 0, 0, 8'h00);
            chk1($sformatf("post-reset quiet%0d irq", i), irq, 1'b0);
        end
        cyc(8'h00, C, 0, 1, 8'h00);
        chk_out("post-reset read cmd", 1'b0, 8'd8, 8'h00, 1'b1);
        cyc(8'h00, M, 0, 1, 8'h00);
        chk_out("post-reset read mask", 1'b0, 8'd8, 8'h00, 1'b1);

        // IRQ0 re-pulsed on its own issue edge: set wins, reissue right after EOI
        cyc(8'h01, X, 0, 0, 8'h00);
        cyc(8'h01, X, 0, 0, 8'h00);
        chk_out("repulse issue", 1'b1, 8'd8, 8'h00, 1'b0);
        cyc(8'h00, X, 0, 0, 8'h00);
        chk1("repulse no second toggle", irq, 1'b1);
        cyc(8'h00, C, 0, 1, 8'h00);
        chk_out("repulse irr read", 1'b1, 8'd8, 8'h01, 1'b1);
        cyc(8'h00, C, 1, 0, 8'h20);
        chk1("repulse eoi edge", irq, 1'b1);
        cyc(8'h00, X, 0, 0, 8'h00);
        chk_out("repulse reissue", 1'b0, 8'd8, 8'h01, 1'b0);

        // IRQ7 vector, with 252+7 wrapping to 3 on the second instance
        cyc(8'h00, C, 1, 0, 8'h20);
        cyc(8'h80, X, 0, 0, 8'h00);
        cyc(8'h00, X, 0, 0, 8'h00);
        chk1("irq7 irq", irq, 1'b1);
        chk8("irq7 irq_in", irq_in, 8'd15);
        chk1("wrap irq", w_irq, 1'b1);
        chk8("wrap irq_in", w_irq_in, 8'd3);
        cyc(8'h00, C, 1, 0, 8'h0B);
        cyc(8'h00, C, 0, 1, 8'h00);
        chk8("irq7 isr read", port_i, 8'h80);
        chk1("irq7 isr hit", port_hit, 1'b1);
        chk8("wrap isr read", w_port_i, 8'h80);
        chk1("wrap isr hit", w_port_hit, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
